rs485_frame_rx: RTL

RS485_FRAME_RX -- requirements
Module: rs485_frame_rx

---
 rtl/rs485_frame_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rs485_frame_rx.sv
// RS485 frame receiver: stores bytes into frame RAM and closes a frame after an idle gap.
// Optional CRC-16/Modbus check is built only when RS485_CRC16_EN is defined.
`timescale 1ns/1ps
module rs485_frame_rx #(
  parameter int unsigned GAP_TICKS = 560,
  parameter int unsigned MAX_LEN   = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_ack,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic [5:0] ram_waddr,
  output logic       frame_done,
  output logic       frame_pending,
  output logic [6:0] frame_length,
  output logic       frame_overflow,
  output logic       frame_crc_ok
);

  localparam int unsigned GAP_W  = $clog2(GAP_TICKS);
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned ADDR_W = 6;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [GAP_W-1:0]   gap, gap_nxt;
  logic [7:0]         wdata_nxt;
  logic               we_nxt;
  logic [ADDR_W-1:0]  waddr_nxt;
  logic               done_nxt;
  logic               pending_nxt;
  logic [CNT_W-1:0]   length_nxt;
  logic               ovf_nxt;
  logic               start;

`ifdef RS485_CRC16_EN
  logic [15:0] crc, crc_nxt;
  logic        crc_ok, crc_ok_nxt;

  // Reflected CRC-16/Modbus update, one full byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    gap_nxt     = gap;
    we_nxt      = 1'b0;
    wdata_nxt   = ram_wdata;
    waddr_nxt   = ram_waddr;
    done_nxt    = 1'b0;
    pending_nxt = frame_pending;
    length_nxt  = frame_length;
    ovf_nxt     = frame_overflow;
    start       = 1'b0;
`ifdef RS485_CRC16_EN
    crc_nxt     = crc;
    crc_ok_nxt  = crc_ok;
`endif

    case (state)
      IDLE: begin
        if (rx_valid) start = 1'b1;
      end
      RECV: begin
        if (rx_valid) begin
          gap_nxt = '0;
`ifdef RS485_CRC16_EN
          crc_nxt = crc16_byte(crc, rx_data);
`endif
          if (count < MAX_CNT) begin
            we_nxt    = 1'b1;
            waddr_nxt = ADDR_W'(count);
            wdata_nxt = rx_data;
            count_nxt = count + CNT_W'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
        end else begin
          if (gap != GAP_LAST) gap_nxt = gap + GAP_W'(1);
          // Idle gap long enough: close the frame.
          if (gap_nxt == GAP_LAST) begin
            state_nxt   = DONE;
            done_nxt    = 1'b1;
            pending_nxt = 1'b1;
            length_nxt  = count;
`ifdef RS485_CRC16_EN
            crc_ok_nxt  = (crc == 16'h0000) && (count >= CNT_W'(3));
`endif
          end
        end
      end
      DONE: begin
        if (frame_ack) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b0;
`ifdef RS485_CRC16_EN
          crc_nxt     = 16'hFFFF;
`endif
          if (rx_valid) start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // First byte of a new frame, from IDLE or from an acknowledged DONE.
    if (start) begin
      state_nxt   = RECV;
      we_nxt      = 1'b1;
      waddr_nxt   = '0;
      wdata_nxt   = rx_data;
      count_nxt   = CNT_W'(1);
      gap_nxt     = '0;
      ovf_nxt     = 1'b0;
      pending_nxt = 1'b0;
`ifdef RS485_CRC16_EN
      crc_nxt     = crc16_byte(16'hFFFF, rx_data);
      crc_ok_nxt  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      gap            <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      ram_waddr      <= '0;
      frame_done     <= 1'b0;
      frame_pending  <= 1'b0;
      frame_length   <= '0;
      frame_overflow <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      gap            <= gap_nxt;
      ram_wdata      <= wdata_nxt;
      ram_we         <= we_nxt;
      ram_waddr      <= waddr_nxt;
      frame_done     <= done_nxt;
      frame_pending  <= pending_nxt;
      frame_length   <= length_nxt;
      frame_overflow <= ovf_nxt;
    end
  end

`ifdef RS485_CRC16_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc    <= 16'hFFFF;
      crc_ok <= 1'b0;
    end else begin
      crc    <= crc_nxt;
      crc_ok <= crc_ok_nxt;
    end
  end

  assign frame_crc_ok = crc_ok;
`else
  assign frame_crc_ok = frame_pending;
`endif

endmodule
